// File: rtl/roce_write_tx_scheduler_if.sv
// Descriptor bus from the RDMA WRITE scheduler (master) to the RoCE TX framer (slave).
interface roce_write_tx_scheduler_if;
    logic        m_desc_valid;
    logic        m_desc_ready;
    logic [7:0]  m_bth_op_code;
    logic [23:0] m_bth_psn;
    logic [23:0] m_bth_dest_qp;
    logic        m_bth_ack_req;
    logic        m_reth_valid;
    logic [63:0] m_reth_v_addr;
    logic [31:0] m_reth_r_key;
    logic [31:0] m_reth_length;
    logic [31:0] m_imm_data;
    logic [15:0] m_payload_length;
    logic [31:0] m_ip_dest_ip;

    modport master (
        output m_desc_valid, m_bth_op_code, m_bth_psn, m_bth_dest_qp, m_bth_ack_req,
               m_reth_valid, m_reth_v_addr, m_reth_r_key, m_reth_length, m_imm_data,
               m_payload_length, m_ip_dest_ip,
        input  m_desc_ready
    );

    modport slave (
        input  m_desc_valid, m_bth_op_code, m_bth_psn, m_bth_dest_qp, m_bth_ack_req,
               m_reth_valid, m_reth_v_addr, m_reth_r_key, m_reth_length, m_imm_data,
               m_payload_length, m_ip_dest_ip,
        output m_desc_ready
    );
endinterface

// File: rtl/roce_write_tx_scheduler.sv
// Splits one RDMA WRITE into PMTU-sized RoCEv2 descriptors (FIRST/MIDDLE/LAST/ONLY).
// Optional macro ROCE_WRITE_IMM_EN: WRITE-with-immediate opcodes and a transfer counter in m_imm_data.
module roce_write_tx_scheduler #(
    parameter int PMTU_SHIFT = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_start_transfer,
    input  logic        s_metadata_valid,
    input  logic [31:0] s_dma_length,
    input  logic [31:0] s_r_key,
    input  logic [23:0] s_rem_qpn,
    input  logic [23:0] s_loc_psn,
    input  logic [63:0] s_rem_addr,
    input  logic [31:0] s_rem_ip_addr,
    roce_write_tx_scheduler_if.master desc,
    output logic [23:0] next_psn,
    output logic        transfer_done,
    output logic        busy
);
    localparam logic [31:0] PMTU      = 32'd1 << PMTU_SHIFT;
    localparam logic [7:0]  OP_FIRST  = 8'h06;
    localparam logic [7:0]  OP_MIDDLE = 8'h07;
`ifdef ROCE_WRITE_IMM_EN
    localparam logic [7:0]  OP_LAST   = 8'h09;
    localparam logic [7:0]  OP_ONLY   = 8'h0B;
`else
    localparam logic [7:0]  OP_LAST   = 8'h08;
    localparam logic [7:0]  OP_ONLY   = 8'h0A;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic        last;
        logic [7:0]  op;
        logic [15:0] len;
    } seg_t;

    state_t      state_r;
    logic        start_d_r;
    logic [31:0] remaining_r;
    logic [23:0] next_psn_r;
    logic        transfer_done_r;
    logic        busy_r;

    logic        accept_s;
    logic        advance_s;
    logic [31:0] rem_after_s;
    seg_t        first_seg_s;
    seg_t        next_seg_s;

    // A segment is the last one when what is left fits in a single PMTU (covers zero length too).
    function automatic seg_t plan_seg(input logic [31:0] rem, input logic first);
        seg_t s;
        s.last = (rem <= PMTU);
        s.len  = s.last ? rem[15:0] : PMTU[15:0];
        case ({first, s.last})
            2'b11:   s.op = OP_ONLY;
            2'b10:   s.op = OP_FIRST;
            2'b01:   s.op = OP_LAST;
            default: s.op = OP_MIDDLE;
        endcase
        return s;
    endfunction

    assign accept_s    = (state_r == ST_IDLE) & s_start_transfer & ~start_d_r & s_metadata_valid;
    assign advance_s   = (state_r == ST_ISSUE) & desc.m_desc_valid & desc.m_desc_ready & ~desc.m_bth_ack_req;
    assign rem_after_s = remaining_r - {16'd0, desc.m_payload_length};
    assign first_seg_s = plan_seg(s_dma_length, 1'b1);
    assign next_seg_s  = plan_seg(rem_after_s, 1'b0);

    // Transfer sequencer: latches the request, then walks the segments one handshake at a time.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r               <= ST_IDLE;
            start_d_r             <= 1'b0;
            remaining_r           <= 32'd0;
            next_psn_r            <= 24'd0;
            transfer_done_r       <= 1'b0;
            busy_r                <= 1'b0;
            desc.m_desc_valid     <= 1'b0;
            desc.m_bth_op_code    <= 8'd0;
            desc.m_bth_psn        <= 24'd0;
            desc.m_bth_dest_qp    <= 24'd0;
            desc.m_bth_ack_req    <= 1'b0;
            desc.m_reth_valid     <= 1'b0;
            desc.m_reth_v_addr    <= 64'd0;
            desc.m_reth_r_key     <= 32'd0;
            desc.m_reth_length    <= 32'd0;
            desc.m_payload_length <= 16'd0;
            desc.m_ip_dest_ip     <= 32'd0;
        end else begin
            start_d_r       <= s_start_transfer;
            transfer_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        remaining_r           <= s_dma_length;
                        desc.m_bth_psn        <= s_loc_psn;
                        desc.m_bth_dest_qp    <= s_rem_qpn;
                        desc.m_reth_v_addr    <= s_rem_addr;
                        desc.m_reth_r_key     <= s_r_key;
                        desc.m_reth_length    <= s_dma_length;
                        desc.m_ip_dest_ip     <= s_rem_ip_addr;
                        desc.m_bth_op_code    <= first_seg_s.op;
                        desc.m_payload_length <= first_seg_s.len;
                        desc.m_bth_ack_req    <= first_seg_s.last;
                        desc.m_reth_valid     <= 1'b1;
                        desc.m_desc_valid     <= 1'b1;
                        busy_r                <= 1'b1;
                        state_r               <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (desc.m_desc_valid && desc.m_desc_ready) begin
                        remaining_r <= rem_after_s;
                        next_psn_r  <= desc.m_bth_psn + 24'd1;
                        if (desc.m_bth_ack_req) begin
                            desc.m_desc_valid <= 1'b0;
                            transfer_done_r   <= 1'b1;
                            state_r           <= ST_DONE;
                        end else begin
                            desc.m_bth_psn        <= desc.m_bth_psn + 24'd1;
                            desc.m_bth_op_code    <= next_seg_s.op;
                            desc.m_payload_length <= next_seg_s.len;
                            desc.m_bth_ack_req    <= next_seg_s.last;
                            desc.m_reth_valid     <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    desc.m_desc_valid <= 1'b0;
                    busy_r            <= 1'b0;
                    state_r           <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ROCE_WRITE_IMM_EN
    logic [31:0] xfer_cnt_r;

    // Completed-transfer counter; its value rides on the LAST/ONLY descriptor as the immediate.
    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_cnt_r      <= 32'd0;
            desc.m_imm_data <= 32'd0;
        end else begin
            if (state_r == ST_DONE) begin
                xfer_cnt_r <= xfer_cnt_r + 32'd1;
            end
            if (accept_s) begin
                desc.m_imm_data <= first_seg_s.last ? xfer_cnt_r : 32'd0;
            end else if (advance_s) begin
                desc.m_imm_data <= next_seg_s.last ? xfer_cnt_r : 32'd0;
            end
        end
    end
`else
    assign desc.m_imm_data = 32'd0;
`endif

    assign next_psn      = next_psn_r;
    assign transfer_done = transfer_done_r;
    assign busy          = busy_r;
endmodule

// File: tb/tb_roce_write_tx_scheduler.sv
// Scoreboard bench: the driver pushes expected descriptors computed per transfer; a negedge monitor pops and compares.
module tb_roce_write_tx_scheduler;
    localparam int PMTU_SHIFT = 10;
    localparam int PMTU = 1 << PMTU_SHIFT;
`ifdef ROCE_WRITE_IMM_EN
    localparam bit IMM = 1'b1;
`else
    localparam bit IMM = 1'b0;
`endif
    typedef logic [265:0] desc_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_start_transfer = 1'b0;
    logic        s_metadata_valid = 1'b0;
    logic [31:0] s_dma_length = 32'd0;
    logic [31:0] s_r_key = 32'd0;
    logic [23:0] s_rem_qpn = 24'd0;
    logic [23:0] s_loc_psn = 24'd0;
    logic [63:0] s_rem_addr = 64'd0;
    logic [31:0] s_rem_ip_addr = 32'd0;
    logic [23:0] next_psn;
    logic        transfer_done;
    logic        busy;

    roce_write_tx_scheduler_if bus();

    roce_write_tx_scheduler #(.PMTU_SHIFT(PMTU_SHIFT)) dut (
        .clk(clk), .rst(rst),
        .s_start_transfer(s_start_transfer), .s_metadata_valid(s_metadata_valid),
        .s_dma_length(s_dma_length), .s_r_key(s_r_key), .s_rem_qpn(s_rem_qpn),
        .s_loc_psn(s_loc_psn), .s_rem_addr(s_rem_addr), .s_rem_ip_addr(s_rem_ip_addr),
        .desc(bus), .next_psn(next_psn), .transfer_done(transfer_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_fail = 0;
    desc_t exp_q[$];
    logic [23:0] done_q[$];
    int    hs_cycles[$];
    int    cyc = 0;
    int    last_hs_cyc = -10;
    int    done_count = 0;
    int    exp_done = 0;
    int    model_xfers = 0;
    int    ready_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic desc_t cur_desc();
        return {bus.m_bth_op_code, bus.m_bth_psn, bus.m_bth_dest_qp, bus.m_bth_ack_req,
                bus.m_reth_valid, bus.m_reth_v_addr, bus.m_reth_r_key, bus.m_reth_length,
                bus.m_imm_data, bus.m_payload_length, bus.m_ip_dest_ip};
    endfunction

    // Transfer-level reference: segment list from length, PMTU and starting PSN.
    task automatic push_transfer(input logic [31:0] len, input logic [23:0] psn, input logic [23:0] qp,
                                 input logic [63:0] va, input logic [31:0] rk, input logic [31:0] ip);
        longint unsigned n, seg, rest;
        logic [7:0]  op;
        logic [31:0] imm;
        bit first, last;
        n = (len == 32'd0) ? 1 : (longint'(len) + PMTU - 1) / PMTU;
        for (longint unsigned i = 0; i < n; i++) begin
            first = (i == 0);
            last  = (i == n - 1);
            rest  = longint'(len) - i * PMTU;
            seg   = (rest < PMTU) ? rest : PMTU;
            if (n == 1)     op = IMM ? 8'h0B : 8'h0A;
            else if (first) op = 8'h06;
            else if (last)  op = IMM ? 8'h09 : 8'h08;
            else            op = 8'h07;
            imm = (IMM && last) ? 32'(model_xfers) : 32'd0;
            exp_q.push_back({op, 24'(psn + i), qp, last, first, va, rk, len, imm, 16'(seg), ip});
        end
        done_q.push_back(24'(psn + n));
        exp_done++;
        model_xfers++;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Called at posedge+1; raises start for 1+hold cycles, then scrambles the fields.
    task automatic start_xfer(input logic [31:0] len, input logic [23:0] psn, input bit md,
                              input bit expect_acc, input int hold);
        logic [23:0] qp;
        logic [63:0] va;
        logic [31:0] rk, ip;
        qp = 24'($urandom); va = {$urandom, $urandom}; rk = $urandom; ip = $urandom;
        s_dma_length = len; s_loc_psn = psn; s_rem_qpn = qp;
        s_rem_addr = va; s_r_key = rk; s_rem_ip_addr = ip;
        s_metadata_valid = md;
        s_start_transfer = 1'b1;
        if (expect_acc) push_transfer(len, psn, qp, va, rk, ip);
        cycles(1);
        if (expect_acc) begin
            check("latency_valid", bus.m_desc_valid, 1);
            check("latency_busy", busy, 1);
        end
        s_dma_length = $urandom; s_loc_psn = 24'($urandom); s_rem_qpn = 24'($urandom);
        s_rem_addr = {$urandom, $urandom}; s_r_key = $urandom; s_rem_ip_addr = $urandom;
        cycles(hold);
        s_start_transfer = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (done_count < exp_done && t < 400) begin
            cycles(1);
            t++;
        end
        check("done_within_budget", done_count, exp_done);
    endtask

    initial forever begin
        @(posedge clk); #1;
        if (ready_mode == 1) bus.m_desc_ready = 1'($urandom_range(0, 1));
    end

    desc_t snap;
    bit    have_snap = 1'b0;
    bit    busy_chk = 1'b0;

    always @(negedge clk) begin
        desc_t cur;
        desc_t e;
        cur = cur_desc();
        if (busy_chk) begin
            check("busy_fall", busy, 0);
            busy_chk = 1'b0;
        end
        if (have_snap && !rst) begin
            check("hold_valid", bus.m_desc_valid, 1);
            check("hold_stable", cur, snap);
        end
        have_snap = bus.m_desc_valid && !bus.m_desc_ready && !rst;
        snap = cur;
        if (!rst && bus.m_desc_valid && bus.m_desc_ready) begin
            hs_cycles.push_back(cyc);
            last_hs_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_desc: got %0h expected none", cur);
            end else begin
                e = exp_q.pop_front();
                check("desc", cur, e);
            end
        end
        if (!rst && transfer_done) begin
            done_count++;
            check("done_after_last_hs", cyc, last_hs_cyc + 1);
            check("busy_at_done", busy, 1);
            if (done_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_done: got pulse expected none");
            end else begin
                check("next_psn_at_done", next_psn, done_q.pop_front());
            end
            busy_chk = 1'b1;
        end
    end

    initial begin
        logic [31:0] len;
        logic [23:0] psn;
        bus.m_desc_ready = 1'b1;
        cycles(3);
        check("rst_valid", bus.m_desc_valid, 0);
        check("rst_done", transfer_done, 0);
        check("rst_busy", busy, 0);
        check("rst_next_psn", next_psn, 0);
        check("rst_fields", cur_desc(), 0);

        // Full-size split, start held high through reset release.
        s_dma_length = 32'h1000; s_loc_psn = 24'h000010; s_rem_qpn = 24'h123456;
        s_rem_addr = 64'h0000_0001_8000_0000; s_r_key = 32'hCAFE_0001; s_rem_ip_addr = 32'h0A00_0002;
        s_metadata_valid = 1'b1; s_start_transfer = 1'b1;
        push_transfer(32'h1000, 24'h000010, 24'h123456, 64'h0000_0001_8000_0000, 32'hCAFE_0001, 32'h0A00_0002);
        hs_cycles.delete();
        rst = 1'b0;
        cycles(1);
        cycles(1);
        check("post_rst_start_valid", bus.m_desc_valid, 1);
        s_start_transfer = 1'b0;
        wait_done();
        check("b2b_count", hs_cycles.size(), 4);
        if (hs_cycles.size() > 0) check("b2b_span", hs_cycles[$] - hs_cycles[0], 3);
        check("split_next_psn", next_psn, 24'h000014);

        start_xfer(32'd2049, 24'h000100, 1'b1, 1'b1, 0);
        wait_done();
        start_xfer(32'd0, 24'h000200, 1'b1, 1'b1, 0);
        wait_done();

        // PSN wrap with backpressure on the MIDDLE descriptor.
        start_xfer(32'd3072, 24'hFFFFFE, 1'b1, 1'b1, 0);
        cycles(1);
        bus.m_desc_ready = 1'b0;
        cycles(5);
        bus.m_desc_ready = 1'b1;
        wait_done();
        check("wrap_next_psn", next_psn, 24'h000001);

        // Start rise while busy is ignored.
        ready_mode = 1;
        start_xfer(32'd4096, 24'h000300, 1'b1, 1'b1, 0);
        cycles(1);
        start_xfer(32'd4096, 24'h000400, 1'b1, 1'b0, 0);
        wait_done();
        cycles(10);
        check("busy_rise_no_extra", exp_q.size(), 0);
        check("busy_rise_done_count", done_count, exp_done);
        ready_mode = 0;
        bus.m_desc_ready = 1'b1;

        // Level held for 10 cycles gives one transfer.
        start_xfer(32'd100, 24'h000500, 1'b1, 1'b1, 9);
        wait_done();
        cycles(5);
        check("held_done_count", done_count, exp_done);
        check("held_idle", busy, 0);

        // Rise without metadata is ignored.
        start_xfer(32'd64, 24'h000600, 1'b0, 1'b0, 0);
        cycles(5);
        check("nometa_busy", busy, 0);
        check("nometa_valid", bus.m_desc_valid, 0);

        // Reset during the 2nd of 4 descriptors.
        start_xfer(32'd4096, 24'h000700, 1'b1, 1'b1, 0);
        cycles(1);
        bus.m_desc_ready = 1'b0;
        rst = 1'b1;
        exp_q.delete(); done_q.delete();
        exp_done = done_count; model_xfers = 0;
        cycles(1);
        check("midrst_valid", bus.m_desc_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_next_psn", next_psn, 0);
        rst = 1'b0;
        bus.m_desc_ready = 1'b1;
        start_xfer(32'd4096, 24'h000800, 1'b1, 1'b1, 0);
        wait_done();

        // Back-to-back short transfers.
        start_xfer(32'd100, 24'h000900, 1'b1, 1'b1, 0);
        wait_done();
        start_xfer(32'd100, 24'h000A00, 1'b1, 1'b1, 0);
        wait_done();

        ready_mode = 1;
        for (int k = 0; k < 25; k++) begin
            case ($urandom_range(0, 3))
                0:       len = 32'($urandom_range(0, PMTU));
                1:       len = 32'(PMTU * $urandom_range(1, 4));
                2:       len = 32'($urandom_range(0, 5 * PMTU));
                default: len = 32'(PMTU * $urandom_range(0, 2) + 1);
            endcase
            psn = ($urandom_range(0, 1) == 1) ? 24'($urandom) : 24'hFFFFFF - 24'($urandom_range(0, 3));
            start_xfer(len, psn, 1'b1, 1'b1, 0);
            wait_done();
            cycles($urandom_range(0, 2));
        end
        ready_mode = 0;
        bus.m_desc_ready = 1'b1;
        cycles(5);
        check("final_desc_queue_empty", exp_q.size(), 0);
        check("final_done_queue_empty", done_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
